// File: rtl/burst_line_port_if.sv
`default_nettype none
// ============================================================================
// Module      : burst_line_port_if
// Description : Bundles the requester side and the BurstRAM side of the
//               line port. The slave modport is the line port itself; the
//               master modport is the environment around it (requester and
//               BurstRAM together).
// Revision    : 1.0 - initial release
// ============================================================================
interface burst_line_port_if #(
    parameter int BURST_COUNT        = 4,
    parameter int DEPTH_BITWIDTH     = 4,
    parameter int LINE_ADDR_BITWIDTH = DEPTH_BITWIDTH - $clog2(BURST_COUNT)
);
    // Requester side
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [LINE_ADDR_BITWIDTH-1:0] req_addr;
    logic [64*BURST_COUNT-1:0]     req_wr_line;
    logic                          resp_valid;
    logic [64*BURST_COUNT-1:0]     resp_rd_line;

    // BurstRAM side
    logic                          cmd;
    logic                          cmd_en;
    logic [DEPTH_BITWIDTH-1:0]     addr;
    logic [63:0]                   wr_data;
    logic [7:0]                    data_mask;
    logic [63:0]                   rd_data;
    logic                          rd_data_valid;
    logic                          busy;

    modport slave (
        input  req_valid, req_write, req_addr, req_wr_line,
        input  rd_data, rd_data_valid, busy,
        output req_ready, resp_valid, resp_rd_line,
        output cmd, cmd_en, addr, wr_data, data_mask
    );

    modport master (
        output req_valid, req_write, req_addr, req_wr_line,
        output rd_data, rd_data_valid, busy,
        input  req_ready, resp_valid, resp_rd_line,
        input  cmd, cmd_en, addr, wr_data, data_mask
    );
endinterface
`default_nettype wire

// File: rtl/burst_line_port.sv
`default_nettype none
// ============================================================================
// Module      : burst_line_port
// Description : Line-granular front end for BurstRAM. Accepts one cache-line
//               read or write at a time, issues a single burst command,
//               streams or collects BURST_COUNT 64-bit beats and returns a
//               one-cycle completion pulse. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_line_port #(
    parameter int BURST_COUNT        = 4,
    parameter int DEPTH_BITWIDTH     = 4,
    parameter int LINE_ADDR_BITWIDTH = DEPTH_BITWIDTH - $clog2(BURST_COUNT)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    burst_line_port_if.slave  bus
);

    localparam int c_cnt_w  = $clog2(BURST_COUNT);
    localparam int c_line_w = 64 * BURST_COUNT;

    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BURST_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_WR_BEATS = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Registered outputs
    logic                          r_req_ready;
    logic                          r_resp_valid;
    logic [c_line_w-1:0]           r_resp_rd_line;
    logic                          r_cmd;
    logic                          r_cmd_en;
    logic [DEPTH_BITWIDTH-1:0]     r_addr;
    logic [63:0]                   r_wr_data;

    // Internal state
    logic [c_cnt_w-1:0]            r_beat_cnt;
    logic [c_line_w-1:0]           r_rd_buf;
    logic                          r_lat_write;
    logic [LINE_ADDR_BITWIDTH-1:0] r_lat_addr;
    logic [c_line_w-1:0]           r_lat_line;

    // Next-state values
    logic                          w_req_ready_nxt;
    logic                          w_resp_valid_nxt;
    logic [c_line_w-1:0]           w_resp_rd_line_nxt;
    logic                          w_cmd_nxt;
    logic                          w_cmd_en_nxt;
    logic [DEPTH_BITWIDTH-1:0]     w_addr_nxt;
    logic [63:0]                   w_wr_data_nxt;
    logic [c_cnt_w-1:0]            w_beat_cnt_nxt;
    logic [c_line_w-1:0]           w_rd_buf_nxt;
    logic                          w_lat_write_nxt;
    logic [LINE_ADDR_BITWIDTH-1:0] w_lat_addr_nxt;
    logic [c_line_w-1:0]           w_lat_line_nxt;

    // Request acceptance and command source selection
    logic                          w_accept;
    logic                          w_issue;
    logic                          w_src_write;
    logic [LINE_ADDR_BITWIDTH-1:0] w_src_addr;
    logic [c_line_w-1:0]           w_src_line;
    logic [c_cnt_w-1:0]            w_beat_inc;

    // req_ready is only ever high while the FSM sits in IDLE.
    assign w_accept = r_req_ready && bus.req_valid;

    // The accept edge doubles as the first busy sample of the command phase,
    // so an unstalled command strobe lands in the cycle right after accept.
    // Later samples come from the registered copy held in CMD.
    assign w_issue     = (w_accept || (r_state == S_CMD)) && !bus.busy;
    assign w_src_write = (r_state == S_IDLE) ? bus.req_write   : r_lat_write;
    assign w_src_addr  = (r_state == S_IDLE) ? bus.req_addr    : r_lat_addr;
    assign w_src_line  = (r_state == S_IDLE) ? bus.req_wr_line : r_lat_line;
    assign w_beat_inc  = r_beat_cnt + c_cnt_one;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; all outputs are computed one
    // cycle ahead so every port is driven straight from a flop.
    always_comb begin
        w_state_nxt        = r_state;
        w_resp_valid_nxt   = 1'b0;
        w_cmd_en_nxt       = 1'b0;
        w_resp_rd_line_nxt = r_resp_rd_line;
        w_cmd_nxt          = r_cmd;
        w_addr_nxt         = r_addr;
        w_wr_data_nxt      = r_wr_data;
        w_beat_cnt_nxt     = r_beat_cnt;
        w_rd_buf_nxt       = r_rd_buf;
        w_lat_write_nxt    = r_lat_write;
        w_lat_addr_nxt     = r_lat_addr;
        w_lat_line_nxt     = r_lat_line;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_lat_write_nxt = bus.req_write;
                    w_lat_addr_nxt  = bus.req_addr;
                    w_lat_line_nxt  = bus.req_wr_line;
                    if (bus.busy) begin
                        w_state_nxt = S_CMD;
                    end
                end
            end

            S_CMD: begin
                // Waiting for BurstRAM; the issue block below takes over
                // on the first cycle busy is low.
            end

            S_WR_BEATS: begin
                if (r_beat_cnt == c_cnt_last) begin
                    w_state_nxt      = S_DONE;
                    w_resp_valid_nxt = 1'b1;
                end else begin
                    w_beat_cnt_nxt = w_beat_inc;
                    w_wr_data_nxt  = r_lat_line[{w_beat_inc, 6'd0} +: 64];
                end
            end

            S_RD_WAIT: begin
                if (bus.rd_data_valid) begin
                    w_rd_buf_nxt[{r_beat_cnt, 6'd0} +: 64] = bus.rd_data;
                    w_beat_cnt_nxt = w_beat_inc;
                    if (r_beat_cnt == c_cnt_last) begin
                        // Publish the whole line only once it is complete.
                        w_resp_rd_line_nxt = w_rd_buf_nxt;
                        w_resp_valid_nxt   = 1'b1;
                        w_state_nxt        = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_cmd_en_nxt   = 1'b1;
            w_cmd_nxt      = w_src_write;
            w_addr_nxt     = {w_src_addr, {c_cnt_w{1'b0}}};
            w_beat_cnt_nxt = '0;
            if (w_src_write) begin
                w_wr_data_nxt = w_src_line[63:0];
                w_state_nxt   = S_WR_BEATS;
            end else begin
                w_state_nxt   = S_RD_WAIT;
            end
        end

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req_ready    <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_rd_line <= '0;
            r_cmd          <= 1'b0;
            r_cmd_en       <= 1'b0;
            r_addr         <= '0;
            r_wr_data      <= '0;
            r_beat_cnt     <= '0;
            r_rd_buf       <= '0;
            r_lat_write    <= 1'b0;
            r_lat_addr     <= '0;
            r_lat_line     <= '0;
        end else begin
            r_req_ready    <= w_req_ready_nxt;
            r_resp_valid   <= w_resp_valid_nxt;
            r_resp_rd_line <= w_resp_rd_line_nxt;
            r_cmd          <= w_cmd_nxt;
            r_cmd_en       <= w_cmd_en_nxt;
            r_addr         <= w_addr_nxt;
            r_wr_data      <= w_wr_data_nxt;
            r_beat_cnt     <= w_beat_cnt_nxt;
            r_rd_buf       <= w_rd_buf_nxt;
            r_lat_write    <= w_lat_write_nxt;
            r_lat_addr     <= w_lat_addr_nxt;
            r_lat_line     <= w_lat_line_nxt;
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rd_line = r_resp_rd_line;
    assign bus.cmd          = r_cmd;
    assign bus.cmd_en       = r_cmd_en;
    assign bus.addr         = r_addr;
    assign bus.wr_data      = r_wr_data;
    // Full-word writes only: no byte is ever masked.
    assign bus.data_mask    = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_burst_line_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_line_port
// Description : Self-checking bench for burst_line_port with a behavioural
//               BurstRAM (latency L=4, init busy) and a line-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_line_port;

    localparam int BC       = 4;
    localparam int DB       = 4;
    localparam int LAB      = 2;
    localparam int L        = 4;
    localparam int INIT_CYC = 12;

    logic clk = 1'b0;
    logic rst;

    burst_line_port_if #(.BURST_COUNT(BC), .DEPTH_BITWIDTH(DB), .LINE_ADDR_BITWIDTH(LAB)) bus ();

    burst_line_port #(.BURST_COUNT(BC), .DEPTH_BITWIDTH(DB), .LINE_ADDR_BITWIDTH(LAB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural BurstRAM ----------------
    logic [63:0] mem [16] = '{
        64'h3F5A2E14B7C6A980, 64'h9D8E2F17AB4C3E6F, 64'hA1C3F7E2D5B8A9C4, 64'h7D4E9F2C1B6A3D8F,
        64'h6C4B9A8D2F5E3C7A, 64'hE1A7D0B5C8F3E6A9, 64'hF8E9D2C3B4A5F6E7, 64'hD4E7F2C5B8A3D6E9,
        64'hC0DE000000000008, 64'hC0DE000000000009, 64'hC0DE00000000000A, 64'hC0DE00000000000B,
        64'hC0DE00000000000C, 64'hC0DE00000000000D, 64'hC0DE00000000000E, 64'hC0DE00000000000F};
    int          init_cnt  = 0;
    logic        init_busy;
    logic        ext_busy  = 1'b0;
    bit          gap_en    = 1'b0;
    logic        m_rdv     = 1'b0;
    logic [63:0] m_rdd     = '0;
    logic        s_rdv     = 1'b0;
    logic [63:0] s_rdd     = '0;
    logic        rd_active = 1'b0;
    int          rd_cd     = 0;
    logic [3:0]  rd_idx    = '0;
    logic [3:0]  rd_base   = '0;
    int          wr_left   = 0;
    logic [3:0]  wr_ptr    = '0;

    assign init_busy         = (init_cnt < INIT_CYC);
    assign bus.busy          = init_busy | ext_busy;
    assign bus.rd_data_valid = m_rdv | s_rdv;
    assign bus.rd_data       = s_rdv ? s_rdd : m_rdd;

    always @(posedge clk) begin
        if (init_cnt < INIT_CYC) init_cnt <= init_cnt + 1;
        m_rdv <= 1'b0;
        if (wr_left > 0) begin
            mem[wr_ptr] <= bus.wr_data;
            wr_ptr      <= wr_ptr + 4'd1;
            wr_left     <= wr_left - 1;
        end
        if (rd_active) begin
            if (rd_cd > 1) begin
                rd_cd <= rd_cd - 1;
            end else if (!(gap_en && ($urandom_range(2) == 0))) begin
                m_rdv  <= 1'b1;
                m_rdd  <= mem[rd_base + rd_idx];
                rd_idx <= rd_idx + 4'd1;
                if (rd_idx == 4'(BC - 1)) rd_active <= 1'b0;
            end
        end
        if (bus.cmd_en) begin
            if (bus.cmd) begin
                mem[bus.addr] <= bus.wr_data;
                wr_ptr        <= bus.addr + 4'd1;
                wr_left       <= BC - 1;
            end else begin
                rd_active <= 1'b1;
                rd_cd     <= L + 1;
                rd_idx    <= '0;
                rd_base   <= bus.addr;
            end
        end
    end

    // ---------------- reference model and checking ----------------
    logic [255:0] ref_line [4];
    logic [255:0] last_rd;
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete transaction, called at a negedge.
    task automatic do_txn(input bit wr, input int a, input logic [255:0] line,
                          input int stall, input bit hold, input int next_a);
        int k_cmd, k_resp, first_free, n_cmd, wait_cyc;
        bit seen_free;
        logic [63:0]  beats [BC];
        logic         cmd_o, rdy_o;
        logic [3:0]   addr_o;
        logic [7:0]   mask_o;
        logic [255:0] line_o;
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_addr    = 2'(a);
        bus.req_wr_line = line;
        ext_busy        = (stall > 0);
        wait_cyc        = 0;
        while (!bus.req_ready && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", bus.req_ready, 1);
            return;
        end
        seen_free  = !(init_busy || ext_busy);
        first_free = 0;
        k_cmd = -1; k_resp = -1; n_cmd = 0;
        cmd_o = 1'b0; rdy_o = 1'b1; addr_o = '0; mask_o = 8'hFF; line_o = '0;
        for (int i = 0; i < BC; i++) beats[i] = 'x;
        for (int k = 1; k <= 60 && k_resp < 0; k++) begin
            @(negedge clk);
            if (hold) begin
                bus.req_addr = 2'($urandom);
            end else begin
                bus.req_valid   = 1'b0;
                bus.req_write   = 1'($urandom);
                bus.req_addr    = 2'($urandom);
                bus.req_wr_line = rnd_line();
            end
            if (bus.cmd_en) begin
                n_cmd++;
                if (k_cmd < 0) begin
                    k_cmd = k; cmd_o = bus.cmd; addr_o = bus.addr; mask_o = bus.data_mask;
                end
            end
            if (wr && k_cmd > 0 && (k - k_cmd) < BC) beats[k - k_cmd] = bus.wr_data;
            if (bus.resp_valid) begin
                k_resp = k; line_o = bus.resp_rd_line; rdy_o = bus.req_ready;
                if (hold) bus.req_addr = 2'(next_a);
            end
            if (k == stall) ext_busy = 1'b0;
            if (!seen_free && !(init_busy || ext_busy)) begin
                first_free = k; seen_free = 1'b1;
            end
        end
        ext_busy = 1'b0;
        @(negedge clk);
        chk("resp_pulse_len", bus.resp_valid, 0);
        chk("cmd_cycle", k_cmd, first_free + 1);
        chk("cmd_count", n_cmd, 1);
        chk("cmd_dir", cmd_o, wr);
        chk("cmd_addr", addr_o, a * BC);
        chk("data_mask", mask_o, 0);
        chk("ready_at_resp", rdy_o, 0);
        if (wr) begin
            for (int i = 0; i < BC; i++) chk("wr_beat", beats[i], line[64*i +: 64]);
            chk("wr_resp_cycle", k_resp, k_cmd + BC);
            chk("wr_keeps_rd_line", line_o, last_rd);
            ref_line[a] = line;
        end else begin
            chk("rd_line", line_o, ref_line[a]);
            if (!gap_en) chk("rd_resp_cycle", k_resp, k_cmd + L + BC + 2);
            else         chk("rd_resp_seen", (k_resp > 0), 1);
            last_rd = ref_line[a];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ref_line[0] = {64'h7D4E9F2C1B6A3D8F, 64'hA1C3F7E2D5B8A9C4, 64'h9D8E2F17AB4C3E6F, 64'h3F5A2E14B7C6A980};
        ref_line[1] = {64'hD4E7F2C5B8A3D6E9, 64'hF8E9D2C3B4A5F6E7, 64'hE1A7D0B5C8F3E6A9, 64'h6C4B9A8D2F5E3C7A};
        ref_line[2] = {64'hC0DE00000000000B, 64'hC0DE00000000000A, 64'hC0DE000000000009, 64'hC0DE000000000008};
        ref_line[3] = {64'hC0DE00000000000F, 64'hC0DE00000000000E, 64'hC0DE00000000000D, 64'hC0DE00000000000C};
        last_rd = '0;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wr_line = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_cmd_en", bus.cmd_en, 0);
        chk("rst_cmd", bus.cmd, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_data_mask", bus.data_mask, 0);
        chk("rst_resp_line", bus.resp_rd_line, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready, 1);

        // Init gating: request held during BurstRAM init, read line 0
        do_txn(1'b0, 0, '0, 0, 1'b0, 0);
        // Read line 1
        do_txn(1'b0, 1, '0, 0, 1'b0, 0);
        // Write line 2 then read it back
        do_txn(1'b1, 2, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 1'b0, 0);
        do_txn(1'b0, 2, '0, 0, 1'b0, 0);

        // Stray rd_data_valid in IDLE
        s_rdd = {$urandom, $urandom};
        s_rdv = 1'b1;
        @(negedge clk);
        s_rdv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_no_resp", bus.resp_valid, 0);
        end
        chk("stray_line_kept", bus.resp_rd_line, last_rd);
        chk("stray_still_idle", bus.req_ready, 1);

        // Reset in the middle of a read, after two beats
        begin
            int nb;
            bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 2'd0;
            @(negedge clk);
            bus.req_valid = 1'b0;
            nb = 0;
            for (int k = 0; k < 40 && nb < 2; k++) begin
                @(negedge clk);
                if (bus.rd_data_valid) nb++;
            end
            chk("rst_mid_beats", nb, 2);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("rst_mid_resp", bus.resp_valid, 0);
            chk("rst_mid_cmd_en", bus.cmd_en, 0);
            chk("rst_mid_line", bus.resp_rd_line, 0);
            chk("rst_mid_ready", bus.req_ready, 0);
            rst = 1'b1;
            last_rd = '0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                chk("rst_late_no_resp", bus.resp_valid, 0);
            end
            do_txn(1'b0, 0, '0, 0, 1'b0, 0);
        end

        // Request held high with a wandering address; the queued one follows
        do_txn(1'b0, 3, '0, 2, 1'b1, 1);
        do_txn(1'b0, 1, '0, 0, 1'b0, 0);

        // Randomized traffic with busy stalls and read gaps
        for (int it = 0; it < 10; it++) begin
            bit wr;
            int a, stall;
            wr     = 1'($urandom_range(1));
            a      = $urandom_range(3);
            stall  = $urandom_range(3);
            gap_en = !wr && ($urandom_range(1) == 1);
            do_txn(wr, a, rnd_line(), stall, 1'b0, 0);
            gap_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
